// File: rtl/wdog_ctrl.sv
// Two-stage watchdog: COUNT expiry raises an interrupt, WARN expiry holds a reset request.
// Define WDOG_LOCK_EN to add the LOCK register (0x5) guarding CTRL and LOAD writes.
module wdog_ctrl #(
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WRITE,
  input  logic [3:0]  ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  input  logic        KICK,
  output logic        WDOG_IRQ,
  output logic        WDOG_RST
);

  localparam int unsigned DW = 32;
  localparam int unsigned FW = 8;
  localparam logic [FW-1:0] FIRE_INIT = FW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    WARN  = 2'b10,
    FIRE  = 2'b11
  } state_t;

  state_t        state, state_n;
  logic          ctrl_en, ctrl_irq_en;
  logic [DW-1:0] load_q, cnt, cnt_n;
  logic [FW-1:0] fire_cnt, fire_n;
  logic          irq_pend, rst_seen;
  logic          set_irq, set_rst;
  logic          wr_ok, wr_ctrl, wr_load, wr_stat, kick;

`ifdef WDOG_LOCK_EN
  logic locked;
  assign wr_ok = ~locked;

  // Only the magic key unlocks; any other write relocks.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      locked <= 1'b1;
    else if (WRITE && ADDR == 4'h5)
      locked <= (WDATA != 32'h1ACC_E551);
  end
`else
  assign wr_ok = 1'b1;
`endif

  assign wr_ctrl = WRITE && (ADDR == 4'h0) && wr_ok;
  assign wr_load = WRITE && (ADDR == 4'h1) && wr_ok;
  assign wr_stat = WRITE && (ADDR == 4'h3);
  assign kick    = KICK || (WRITE && (ADDR == 4'h4));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and counters; a kick outranks expiry, a cleared EN outranks everything.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire_n  = fire_cnt;
    set_irq = 1'b0;
    set_rst = 1'b0;
    if (!ctrl_en) begin
      state_n = IDLE;
      cnt_n   = load_q;
    end else begin
      case (state)
        IDLE: begin
          state_n = COUNT;
          cnt_n   = load_q;
        end
        COUNT: begin
          if (kick) begin
            cnt_n = load_q;
          end else if (cnt == '0) begin
            state_n = WARN;
            cnt_n   = load_q;
            set_irq = 1'b1;
          end else begin
            cnt_n = cnt - DW'(1);
          end
        end
        WARN: begin
          if (kick) begin
            state_n = COUNT;
            cnt_n   = load_q;
          end else if (cnt == '0) begin
            state_n = FIRE;
            fire_n  = FIRE_INIT;
          end else begin
            cnt_n = cnt - DW'(1);
          end
        end
        FIRE: begin
          if (fire_cnt == '0) begin
            state_n = COUNT;
            cnt_n   = load_q;
            set_rst = 1'b1;
          end else begin
            fire_n = fire_cnt - FW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Registers, sticky flags (set beats W1C clear) and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      load_q      <= '1;
      cnt         <= '1;
      fire_cnt    <= '0;
      irq_pend    <= 1'b0;
      rst_seen    <= 1'b0;
      WDOG_IRQ    <= 1'b0;
      WDOG_RST    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= WDATA[0];
        ctrl_irq_en <= WDATA[1];
      end
      if (wr_load) load_q <= WDATA;
      cnt      <= cnt_n;
      fire_cnt <= fire_n;
      irq_pend <= (irq_pend & ~(wr_stat & WDATA[0])) | set_irq;
      rst_seen <= (rst_seen & ~(wr_stat & WDATA[1])) | set_rst;
      WDOG_IRQ <= irq_pend & ctrl_irq_en;
      WDOG_RST <= (state_n == FIRE);
    end
  end

  always_comb begin
    RDATA = '0;
    case (ADDR)
      4'h0: RDATA = {30'b0, ctrl_irq_en, ctrl_en};
      4'h1: RDATA = load_q;
      4'h2: RDATA = cnt;
      4'h3: RDATA = {28'b0, state, rst_seen, irq_pend};
`ifdef WDOG_LOCK_EN
      4'h5: RDATA = {31'b0, locked};
`endif
      default: RDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_wdog_ctrl.sv
// Directed bench for wdog_ctrl: expiry timeline, kicks, interrupt flow, EN clear, reset and lock.
module tb_wdog_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WRITE = 1'b0;
  logic [3:0]  ADDR = 4'h0;
  logic [31:0] WDATA = 32'h0;
  logic [31:0] RDATA;
  logic        KICK = 1'b0;
  logic        WDOG_IRQ;
  logic        WDOG_RST;

  int checks = 0;
  int errors = 0;

  wdog_ctrl dut (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .KICK(KICK), .WDOG_IRQ(WDOG_IRQ), .WDOG_RST(WDOG_RST)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    WRITE = 1'b1; ADDR = a; WDATA = d;
    @(posedge CLK);
    #1;
    WRITE = 1'b0; WDATA = 32'h0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    ADDR = a;
    #1;
    d = RDATA;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #1 RST = 1'b1;
    cyc(3);
    RST = 1'b0;
    cyc(1);
    rd(4'h0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp %h", d, 32'h0); end
    rd(4'h1, d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_load got %h exp %h", d, 32'hFFFF_FFFF); end
    rd(4'h2, d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_value got %h exp %h", d, 32'hFFFF_FFFF); end
    rd(4'h3, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp %h", d, 32'h0); end
`ifdef WDOG_LOCK_EN
    rd(4'h5, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_lock got %h exp %h", d, 32'h1); end
`else
    rd(4'h5, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_lock got %h exp %h", d, 32'h0); end
`endif
    checks++; if ({WDOG_IRQ, WDOG_RST} !== 2'b00) begin errors++; $display("FAIL reset_outs got %b exp 00", {WDOG_IRQ, WDOG_RST}); end
  endtask

  task automatic test_lock;
`ifdef WDOG_LOCK_EN
    logic [31:0] d;
    wr(4'h0, 32'h1);
    cyc(2);
    rd(4'h0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL lock_ctrl_ignored got %h exp %h", d, 32'h0); end
    rd(4'h3, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL lock_still_idle got %h exp %h", d, 32'h0); end
    wr(4'h5, 32'h1ACC_E551);
    rd(4'h5, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL lock_unlocked got %h exp %h", d, 32'h0); end
    wr(4'h1, 32'h3);
    wr(4'h0, 32'h1);
    cyc(1);
    rd(4'h3, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL lock_count got %h exp %h", d, 32'h4); end
    wr(4'h5, 32'h0);
    rd(4'h5, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL lock_relocked got %h exp %h", d, 32'h1); end
    wr(4'h1, 32'h9);
    rd(4'h1, d); checks++; if (d !== 32'h3) begin errors++; $display("FAIL lock_load_ignored got %h exp %h", d, 32'h3); end
    wr(4'h4, 32'h0);
    rd(4'h2, d); checks++; if (d !== 32'h3) begin errors++; $display("FAIL lock_kickreg got %h exp %h", d, 32'h3); end
    rd(4'h3, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL lock_kick_state got %h exp %h", d, 32'h4); end
    wr(4'h5, 32'h1ACC_E551);
    wr(4'h0, 32'h0);
    cyc(1);
`endif
  endtask

  task automatic test_expiry;
    logic [31:0] d;
    int hi;
    wr(4'h1, 32'd5);
    wr(4'h0, 32'h1);
    cyc(1);
    rd(4'h3, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL exp_enter_count got %h exp %h", d, 32'h4); end
    rd(4'h2, d); checks++; if (d !== 32'd5) begin errors++; $display("FAIL exp_count_load got %h exp %h", d, 32'd5); end
    cyc(5);
    rd(4'h2, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL exp_count_zero got %h exp %h", d, 32'd0); end
    rd(4'h3, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL exp_still_count got %h exp %h", d, 32'h4); end
    cyc(1);
    rd(4'h3, d); checks++; if (d !== 32'h9) begin errors++; $display("FAIL exp_warn got %h exp %h", d, 32'h9); end
    rd(4'h2, d); checks++; if (d !== 32'd5) begin errors++; $display("FAIL exp_warn_load got %h exp %h", d, 32'd5); end
    cyc(5);
    checks++; if (WDOG_RST !== 1'b0) begin errors++; $display("FAIL exp_rst_early got %b exp 0", WDOG_RST); end
    cyc(1);
    hi = 0;
    while (WDOG_RST === 1'b1 && hi < 40) begin
      hi++;
      cyc(1);
    end
    checks++; if (hi != 16) begin errors++; $display("FAIL exp_rst_width got %0d exp %0d", hi, 16); end
    rd(4'h3, d); checks++; if (d !== 32'h7) begin errors++; $display("FAIL exp_after_fire got %h exp %h", d, 32'h7); end
    wr(4'h3, 32'h3);
    wr(4'h0, 32'h0);
    cyc(1);
    rd(4'h3, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL exp_w1c_idle got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_kick;
    logic [31:0] d;
    wr(4'h1, 32'd3);
    wr(4'h0, 32'h1);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      cyc(2);
      KICK = 1'b1;
      cyc(1);
      KICK = 1'b0;
      rd(4'h3, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL kick_periodic_%0d got %h exp %h", i, d, 32'h4); end
      rd(4'h2, d); checks++; if (d !== 32'd3) begin errors++; $display("FAIL kick_reload_%0d got %h exp %h", i, d, 32'd3); end
    end
    cyc(3);
    rd(4'h2, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL kick_at_zero_pre got %h exp %h", d, 32'd0); end
    KICK = 1'b1;
    cyc(1);
    KICK = 1'b0;
    rd(4'h3, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL kick_beats_expiry got %h exp %h", d, 32'h4); end
    cyc(3);
    wr(4'h4, 32'hDEAD_BEEF);
    rd(4'h3, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL kickreg_state got %h exp %h", d, 32'h4); end
    rd(4'h2, d); checks++; if (d !== 32'd3) begin errors++; $display("FAIL kickreg_reload got %h exp %h", d, 32'd3); end
    rd(4'h4, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL kickreg_read got %h exp %h", d, 32'h0); end
    wr(4'h1, 32'd7);
    rd(4'h2, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL load_deferred got %h exp %h", d, 32'd2); end
    wr(4'h0, 32'h1);
    rd(4'h2, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL ctrl_no_reload got %h exp %h", d, 32'd1); end
    KICK = 1'b1;
    cyc(1);
    KICK = 1'b0;
    rd(4'h2, d); checks++; if (d !== 32'd7) begin errors++; $display("FAIL load_on_kick got %h exp %h", d, 32'd7); end
    checks++; if (WDOG_IRQ !== 1'b0) begin errors++; $display("FAIL kick_irq got %b exp 0", WDOG_IRQ); end
    wr(4'h0, 32'h0);
    cyc(1);
  endtask

  task automatic test_irq;
    logic [31:0] d;
    wr(4'h1, 32'd2);
    wr(4'h0, 32'h3);
    cyc(4);
    rd(4'h3, d); checks++; if (d !== 32'h9) begin errors++; $display("FAIL irq_warn_pend got %h exp %h", d, 32'h9); end
    checks++; if (WDOG_IRQ !== 1'b0) begin errors++; $display("FAIL irq_latency got %b exp 0", WDOG_IRQ); end
    cyc(1);
    checks++; if (WDOG_IRQ !== 1'b1) begin errors++; $display("FAIL irq_assert got %b exp 1", WDOG_IRQ); end
    wr(4'h3, 32'h1);
    rd(4'h3, d); checks++; if (d !== 32'h8) begin errors++; $display("FAIL irq_w1c got %h exp %h", d, 32'h8); end
    checks++; if (WDOG_IRQ !== 1'b1) begin errors++; $display("FAIL irq_clear_latency got %b exp 1", WDOG_IRQ); end
    cyc(1);
    checks++; if (WDOG_IRQ !== 1'b0) begin errors++; $display("FAIL irq_deassert got %b exp 0", WDOG_IRQ); end
    rd(4'h3, d); checks++; if (d !== 32'hC) begin errors++; $display("FAIL irq_fire got %h exp %h", d, 32'hC); end
    cyc(18);
    rd(4'h3, d); checks++; if (d !== 32'h6) begin errors++; $display("FAIL irq_back_count got %h exp %h", d, 32'h6); end
    rd(4'h2, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL irq_zero_pre got %h exp %h", d, 32'd0); end
    wr(4'h3, 32'h1);
    rd(4'h3, d); checks++; if (d !== 32'hB) begin errors++; $display("FAIL irq_set_wins got %h exp %h", d, 32'hB); end
    cyc(1);
    checks++; if (WDOG_IRQ !== 1'b1) begin errors++; $display("FAIL irq_reassert got %b exp 1", WDOG_IRQ); end
    wr(4'h3, 32'h3);
    wr(4'h0, 32'h0);
    cyc(1);
  endtask

  task automatic test_en_clear;
    logic [31:0] d;
    wr(4'h1, 32'd4);
    wr(4'h0, 32'h1);
    cyc(1);
    cyc(5);
    rd(4'h3, d); checks++; if (d !== 32'h9) begin errors++; $display("FAIL en_warn got %h exp %h", d, 32'h9); end
    cyc(2);
    wr(4'h0, 32'h0);
    cyc(1);
    rd(4'h3, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL en_idle_flags got %h exp %h", d, 32'h1); end
    rd(4'h2, d); checks++; if (d !== 32'd4) begin errors++; $display("FAIL en_value_load got %h exp %h", d, 32'd4); end
    checks++; if (WDOG_RST !== 1'b0) begin errors++; $display("FAIL en_rst got %b exp 0", WDOG_RST); end
  endtask

  task automatic test_map;
    logic [31:0] d;
    wr(4'h0, 32'hFFFF_FFFC);
    rd(4'h0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL map_ctrl_bits got %h exp %h", d, 32'h0); end
    wr(4'h5, 32'h1ACC_E551);
    rd(4'h5, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL map_lock_read got %h exp %h", d, 32'h0); end
    wr(4'h7, 32'h1234_5678);
    for (int a = 6; a < 16; a++) begin
      rd(4'(a), d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL map_unused_%0d got %h exp %h", a, d, 32'h0); end
    end
    cyc(1);
    rd(4'h3, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL map_still_idle got %h exp %h", d, 32'h1); end
  endtask

  task automatic test_rst_fire;
    logic [31:0] d;
    wr(4'h3, 32'h3);
    wr(4'h1, 32'd0);
    wr(4'h0, 32'h3);
    cyc(1);
    rd(4'h3, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL load0_count got %h exp %h", d, 32'h4); end
    cyc(1);
    rd(4'h3, d); checks++; if (d !== 32'h9) begin errors++; $display("FAIL load0_warn got %h exp %h", d, 32'h9); end
    cyc(1);
    checks++; if ({WDOG_IRQ, WDOG_RST} !== 2'b11) begin errors++; $display("FAIL load0_fire got %b exp 11", {WDOG_IRQ, WDOG_RST}); end
    cyc(3);
    RST = 1'b1;
    #1;
    checks++; if ({WDOG_IRQ, WDOG_RST} !== 2'b00) begin errors++; $display("FAIL rst_async_outs got %b exp 00", {WDOG_IRQ, WDOG_RST}); end
    rd(4'h0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h exp %h", d, 32'h0); end
    rd(4'h1, d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_load got %h exp %h", d, 32'hFFFF_FFFF); end
    rd(4'h2, d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_value got %h exp %h", d, 32'hFFFF_FFFF); end
    rd(4'h3, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got %h exp %h", d, 32'h0); end
    RST = 1'b0;
    cyc(2);
    rd(4'h3, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_release_idle got %h exp %h", d, 32'h0); end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_expiry;
    test_kick;
    test_irq;
    test_en_clear;
    test_map;
    test_rst_fire;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wdog_ctrl.md
WDOG_CTRL -- requirements
Module: wdog_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16, giving the number of cycles WDOG_RST is held on final expiry (legal 1..255).
REQ-002 The block SHALL have port CLK  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port WRITE  input  1  register write strobe, sampled at the CLK edge.
REQ-005 The block SHALL have port ADDR  input  4  register word address.
REQ-006 The block SHALL have port WDATA  input  32  register write data.
REQ-007 The block SHALL have port RDATA  output  32  register read data, combinational from ADDR.
REQ-008 The block SHALL have port KICK  input  1  hardware kick, level-sampled each cycle.
REQ-009 The block SHALL have port WDOG_IRQ  output  1  registered first-stage timeout interrupt.
REQ-010 The block SHALL have port WDOG_RST  output  1  registered system-reset request.

Function
REQ-011 The register map SHALL be: 0x0 CTRL (bit0 EN, bit1 IRQ_EN), 0x1 LOAD (32-bit), 0x2 VALUE (read-only counter), 0x3 STATUS (bit0 IRQ_PEND W1C, bit1 RST_SEEN W1C, bits[3:2] state code), 0x4 KICKREG (write any value = kick, reads 0); all other addresses read 0 and ignore writes; unused bits read 0.
REQ-012 The FSM SHALL have states IDLE(00), COUNT(01), WARN(10), FIRE(11).
REQ-013 IDLE: counter held at LOAD; EN=1 -> COUNT next cycle with counter=LOAD.
REQ-014 COUNT: counter decrements by 1 per cycle; on a cycle with counter==0 and no kick -> WARN, counter=LOAD, IRQ_PEND set.
REQ-015 WARN: counter decrements; kick -> COUNT with counter=LOAD; counter==0 with no kick -> FIRE.
REQ-016 FIRE: WDOG_RST=1 for exactly RST_CYCLES cycles, then -> COUNT with counter=LOAD, RST_SEEN set, WDOG_RST=0.
REQ-017 Each stage SHALL last exactly LOAD+1 cycles from reload; LOAD=0 gives 1-cycle stages; no wrap below 0.
REQ-018 A kick (KICK=1 or write to 0x4) in COUNT/WARN SHALL reload counter=LOAD and enter COUNT next cycle; a kick coincident with counter==0 wins over expiry; kicks in IDLE/FIRE SHALL be ignored.
REQ-019 A LOAD write SHALL take effect at the next reload only; a write to CTRL keeping EN=1 SHALL NOT reload.
REQ-020 EN cleared in any state SHALL enter IDLE next cycle, deassert WDOG_RST next cycle, retain STATUS flags.
REQ-021 WDOG_IRQ SHALL equal registered (IRQ_PEND & IRQ_EN); it follows IRQ_PEND/IRQ_EN changes with one-cycle latency.
REQ-022 If a W1C clear and a flag-set event occur in the same cycle the set SHALL win.

Reset
REQ-023 On RST: state IDLE, CTRL=0, LOAD=0xFFFFFFFF, counter=0xFFFFFFFF, STATUS flags=0, WDOG_IRQ=0, WDOG_RST=0, asynchronously and mid-operation (including mid-FIRE).

Configuration
REQ-024 Macro WDOG_LOCK_EN defined: register 0x5 LOCK exists; writing 0x1ACCE551 unlocks, any other value locks; reset state locked; writes to CTRL and LOAD while locked SHALL be ignored; 0x5 reads bit0=locked; KICKREG and STATUS unaffected by lock.
REQ-025 WDOG_LOCK_EN undefined: 0x5 reads 0, writes ignored, CTRL/LOAD always writable.

Verification
REQ-026 LOAD=5, EN=1, no kicks -> WARN and IRQ_PEND 6 cycles after entering COUNT; FIRE 6 cycles later; WDOG_RST high exactly 16 cycles; RST_SEEN=1; back in COUNT.
REQ-027 LOAD=3, KICK pulsed every 3 cycles -> state never leaves COUNT, WDOG_IRQ stays 0; KICK on the counter==0 cycle prevents WARN.
REQ-028 IRQ_EN=1, reach WARN -> WDOG_IRQ=1 one cycle after IRQ_PEND; write 0x1 to 0x3 -> WDOG_IRQ=0 one cycle after clear; clear coincident with new expiry -> IRQ_PEND stays 1.
REQ-029 RST asserted during FIRE -> WDOG_RST=0 immediately, all registers at REQ-023 values; EN cleared mid-WARN -> IDLE, VALUE reads LOAD.
REQ-030 With WDOG_LOCK_EN: write CTRL=1 locked -> ignored; write 0x1ACCE551 to 0x5, then CTRL=1 -> COUNT; write 0 to 0x5 -> LOAD write ignored, KICKREG still reloads.
